// File: rtl/axi_stream_sync_fifo.sv
// Purpose: single-clock AXI-Stream FIFO with registered, rule-compliant master handshakes and occupancy/packet counts.
// Latency: one cycle; a beat pushed into an empty FIFO at edge N shows m_axis_tvalid in cycle N+1.
// Backpressure: s_axis_tready is registered (level != depth); when full, a pop does not free a slot until the next cycle.
module axi_stream_sync_fifo #(
   parameter int byte_width = 4,
   parameter int id_width   = 1,
   parameter int dest_width = 1,
   parameter int user_width = 1,
   parameter int depth      = 16
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic [8*byte_width-1:0]         s_axis_tdata,
   input  logic [byte_width-1:0]           s_axis_tstrb,
   input  logic [byte_width-1:0]           s_axis_tkeep,
   input  logic                            s_axis_tlast,
   input  logic [id_width-1:0]             s_axis_tid,
   input  logic [dest_width-1:0]           s_axis_tdest,
   input  logic [user_width-1:0]           s_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [8*byte_width-1:0]         m_axis_tdata,
   output logic [byte_width-1:0]           m_axis_tstrb,
   output logic [byte_width-1:0]           m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic [id_width-1:0]             m_axis_tid,
   output logic [dest_width-1:0]           m_axis_tdest,
   output logic [user_width-1:0]           m_axis_tuser,
   output logic [$clog2(depth+1)-1:0]      level,
   output logic [$clog2(depth+1)-1:0]      pkt_count
);

   localparam int AW = $clog2(depth);
   localparam int LW = $clog2(depth+1);
   localparam int WW = 8*byte_width + 2*byte_width + 1 + id_width + dest_width + user_width;
   localparam logic [LW-1:0] FULL_LVL = LW'(depth);
   localparam logic [LW-1:0] ONE_LVL  = LW'(1);
   localparam logic [AW-1:0] ONE_PTR  = AW'(1);

   // Whole beat stored as one word so every sideband field travels with its data.
   logic [WW-1:0] mem [depth];
   logic [WW-1:0] wr_word;
   logic [WW-1:0] rd_word;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [LW-1:0] level_nxt;
   logic [LW-1:0] pkt_nxt;
   logic          push;
   logic          pop;
   logic          push_last;
   logic          pop_last;

   assign push      = s_axis_tvalid & s_axis_tready;
   assign pop       = m_axis_tvalid & m_axis_tready;
   assign push_last = push & s_axis_tlast;
   assign pop_last  = pop & m_axis_tlast;

   assign wr_word = {s_axis_tlast, s_axis_tuser, s_axis_tdest, s_axis_tid,
                     s_axis_tkeep, s_axis_tstrb, s_axis_tdata};
   // Head entry is read straight from storage; rptr and the head slot only change on a pop,
   // and a push can never land on the head slot while it is valid, so a stalled payload stays put.
   assign rd_word = mem[rptr];
   assign {m_axis_tlast, m_axis_tuser, m_axis_tdest, m_axis_tid,
           m_axis_tkeep, m_axis_tstrb, m_axis_tdata} = rd_word;

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wr_word;
      end
   end

   // Next occupancy and packet count; simultaneous increment and decrement cancel.
   always_comb begin
      level_nxt = level;
      pkt_nxt   = pkt_count;
      if (push && !pop) begin
         level_nxt = level + ONE_LVL;
      end else if (!push && pop) begin
         level_nxt = level - ONE_LVL;
      end
      if (push_last && !pop_last) begin
         pkt_nxt = pkt_count + ONE_LVL;
      end else if (!push_last && pop_last) begin
         pkt_nxt = pkt_count - ONE_LVL;
      end
   end

   // Pointers, counts and both handshake flags; full/empty come from the next level.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr          <= '0;
         rptr          <= '0;
         level         <= '0;
         pkt_count     <= '0;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + ONE_PTR;
         end
         if (pop) begin
            rptr <= rptr + ONE_PTR;
         end
         level         <= level_nxt;
         pkt_count     <= pkt_nxt;
         s_axis_tready <= (level_nxt != FULL_LVL);
         m_axis_tvalid <= (level_nxt != '0);
      end
   end

endmodule

// File: tb/tb_axi_stream_sync_fifo.sv
// Bench for axi_stream_sync_fifo: queue-based reference model, per-cycle compare,
// an m_axis handshake-rule monitor, and directed scenarios with literal expectations.
module tb_axi_stream_sync_fifo;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic        last;
      logic        user;
      logic        dest;
      logic        id;
      logic [3:0]  keep;
      logic [3:0]  strb;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] s_tdata;
   logic [3:0]  s_tstrb;
   logic [3:0]  s_tkeep;
   logic        s_tlast;
   logic [0:0]  s_tid;
   logic [0:0]  s_tdest;
   logic [0:0]  s_tuser;
   logic        m_tvalid;
   logic        m_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic [3:0]  m_tkeep;
   logic        m_tlast;
   logic [0:0]  m_tid;
   logic [0:0]  m_tdest;
   logic [0:0]  m_tuser;
   logic [4:0]  level;
   logic [4:0]  pkt_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_stream_sync_fifo #(
      .byte_width(4), .id_width(1), .dest_width(1), .user_width(1), .depth(DEPTH)
   ) dut (
      .clk(clk), .resetn(resetn),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tstrb(s_tstrb), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
      .level(level), .pkt_count(pkt_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [31:0] d, input logic [3:0] strb, input logic [3:0] keep,
                           input logic last, input logic id, input logic dest, input logic user);
      s_tdata = d; s_tstrb = strb; s_tkeep = keep; s_tlast = last;
      s_tid = id; s_tdest = dest; s_tuser = user;
   endtask

   function automatic beat_t dut_head();
      beat_t b;
      b = '{last: m_tlast, user: m_tuser[0], dest: m_tdest[0], id: m_tid[0],
            keep: m_tkeep, strb: m_tstrb, data: m_tdata};
      return b;
   endfunction

   // ---------------- reference model: a queue of accepted beats ----------------
   beat_t q[$];
   bit    alive = 1'b0;   // set by the first clock edge seen with reset released

   function automatic int model_pkts();
      int n = 0;
      foreach (q[i]) if (q[i].last) n++;
      return n;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            q.delete();
            alive = 1'b0;
         end else begin
            bit    do_push, do_pop;
            beat_t nb;
            do_push = s_tvalid && alive && (q.size() < DEPTH);
            do_pop  = m_tready && (q.size() != 0);
            nb = '{last: s_tlast, user: s_tuser[0], dest: s_tdest[0], id: s_tid[0],
                   keep: s_tkeep, strb: s_tstrb, data: s_tdata};
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(nb);
            alive = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   initial begin
      forever begin
         @(negedge clk);
         check("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
         check("s_tready", 64'(s_tready), 64'(alive && (q.size() < DEPTH)));
         check("level", 64'(level), 64'(q.size()));
         check("pkt_count", 64'(pkt_count), 64'(model_pkts()));
         if (q.size() != 0) check("m_payload", 64'(dut_head()), 64'(q[0]));
      end
   end

   // ---------------- m_axis handshake-rule monitor ----------------
   bit rst_seen = 1'b0;
   initial forever begin
      @(negedge resetn);
      rst_seen = 1'b1;
   end

   initial begin
      bit    stalled = 1'b0;
      beat_t held;
      forever begin
         @(negedge clk);
         if (!resetn) check("axis_tvalid_low_in_reset", 64'(m_tvalid), 64'(0));
         if (rst_seen || !resetn) begin
            stalled  = 1'b0;
            rst_seen = 1'b0;
         end else begin
            if (stalled) begin
               check("axis_tvalid_held", 64'(m_tvalid), 64'(1));
               check("axis_payload_stable", 64'(dut_head()), 64'(held));
            end
            stalled = m_tvalid && !m_tready;
            held    = dut_head();
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      resetn   = 1'b0;
      m_tready = 1'b0;
      s_tvalid = 1'b1;
      set_beat(32'hDEAD_BEEF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);

      // 1: reset holds everything low even with upstream valid asserted
      repeat (3) step();
      check("rst_s_tready", 64'(s_tready), 64'(0));
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_level", 64'(level), 64'(0));
      resetn   = 1'b1;
      s_tvalid = 1'b0;
      step();
      check("rst_release_tready", 64'(s_tready), 64'(1));

      // 2: fill 16 beats with downstream stalled; beat 17 must be refused
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] v;
         v = 32'(i);
         s_tvalid = 1'b1;
         set_beat(v, ~v[3:0], v[3:0] | 4'h1, (i == DEPTH-1), v[0], v[1], v[2]);
         step();
      end
      check("fill_level", 64'(level), 64'(16));
      check("fill_tready", 64'(s_tready), 64'(0));
      check("fill_pkts", 64'(pkt_count), 64'(1));
      set_beat(32'd16, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) step();
      check("beat17_level", 64'(level), 64'(16));

      // 3: drain in order on consecutive cycles
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_valid", 64'(m_tvalid), 64'(1));
         check("drain_data", 64'(m_tdata), 64'(i));
         step();
      end
      check("drain_empty_valid", 64'(m_tvalid), 64'(0));
      check("drain_empty_level", 64'(level), 64'(0));
      m_tready = 1'b0;

      // 4: stalled single packet beat stays bit-stable
      s_tvalid = 1'b1;
      set_beat(32'hA5A5_5A5A, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      s_tvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", 64'(m_tvalid), 64'(1));
         check("stall_data", 64'(m_tdata), 64'hA5A5_5A5A);
         check("stall_keep", 64'(m_tkeep), 64'hF);
         check("stall_last", 64'(m_tlast), 64'(1));
         check("stall_pkts", 64'(pkt_count), 64'(1));
         step();
      end
      m_tready = 1'b1;
      step();
      m_tready = 1'b0;

      // 5: level 8 with packets, then simultaneous push/pop, then a long stream across wrap
      for (int i = 0; i < 8; i++) begin
         s_tvalid = 1'b1;
         set_beat(32'h0000_0100 + 32'(i), 4'b0101, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0);
         step();
      end
      check("pre_pp_level", 64'(level), 64'(8));
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_beat(32'h0000_0200 + 32'(i), 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
         step();
         check("pushpop_level", 64'(level), 64'(8));
         check("pushpop_pkts", 64'(pkt_count), 64'(8));
      end
      for (int i = 0; i < 40; i++) begin
         logic [31:0] v;
         v = 32'h0000_1000 + 32'(i);
         set_beat(v, v[7:4], v[3:0], (i % 5 == 4), v[0], v[1], v[2]);
         step();
      end
      s_tvalid = 1'b0;
      for (int k = 0; k < 40 && m_tvalid; k++) step();
      check("stream_drained_valid", 64'(m_tvalid), 64'(0));
      check("stream_drained_level", 64'(level), 64'(0));
      m_tready = 1'b0;

      // 6: asynchronous reset mid-packet discards everything at once
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b1;
         set_beat(32'h0000_3000 + 32'(i), 4'hF, 4'hF, (i == 1), 1'b0, 1'b0, 1'b0);
         step();
      end
      s_tvalid = 1'b0;
      check("pre_rst_level", 64'(level), 64'(3));
      check("pre_rst_pkts", 64'(pkt_count), 64'(1));
      #1;
      resetn = 1'b0;
      #1;
      check("midrst_level", 64'(level), 64'(0));
      check("midrst_pkts", 64'(pkt_count), 64'(0));
      check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("midrst_s_tready", 64'(s_tready), 64'(0));
      step();
      resetn = 1'b1;
      repeat (2) step();
      check("post_rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("post_rst_level", 64'(level), 64'(0));
      check("post_rst_tready", 64'(s_tready), 64'(1));

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
